// File: rtl/xz_word_serializer.sv
// xz_word_serializer: captures a four-state word, scrubs X/Z to 0,
// and streams the cleaned bits out LSB first on valid/ready.
module xz_word_serializer #(
  parameter int WORD_W = 18,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word,
  input  logic signed [31:0] in_len,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [4:0]        xz_count,
  output logic              xz_flag,
  output logic [FCNT_W-1:0] frames_done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [4:0]        r_remain;
  logic [4:0]        r_xz_count;
  logic              r_xz_flag;
  logic [FCNT_W-1:0] r_frames;

  logic [WORD_W-1:0] w_clean;
  logic [4:0]        w_xz_cnt;
  logic [4:0]        w_len;
  logic              w_last;
  logic              w_take;

  // Only a definite 1 survives; X and Z are counted and become 0.
  always_comb begin
    w_clean  = '0;
    w_xz_cnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_clean[i] = (in_word[i] === 1'b1);
      if (!(in_word[i] === 1'b1) && !(in_word[i] === 1'b0))
        w_xz_cnt = w_xz_cnt + 5'd1;
    end
  end

  always_comb begin
    w_len = 5'd18;
    if (in_len >= 32'sd1 && in_len <= 32'sd18)
      w_len = in_len[4:0];
  end

  assign w_last = (r_state == SHIFT) && (r_remain == 5'd1);
  assign w_take = (r_state == IDLE) && in_valid && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_remain   <= '0;
      r_xz_count <= '0;
      r_xz_flag  <= 1'b0;
      r_frames   <= '0;
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          if (w_take) begin
            r_shreg    <= w_clean;
            r_remain   <= w_len;
            r_xz_count <= w_xz_cnt;
            r_xz_flag  <= (w_xz_cnt != 5'd0);
            r_state    <= SHIFT;
          end
        end
        (r_state == SHIFT): begin
          if (out_ready) begin
            r_remain <= r_remain - 5'd1;
            if (w_last) begin
              r_shreg  <= '0;
              r_frames <= r_frames + FCNT_W'(1);
              r_state  <= IDLE;
            end else begin
              r_shreg <= {1'b0, r_shreg[WORD_W-1:1]};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = rst_n && (r_state == IDLE);
  assign out_valid   = (r_state == SHIFT);
  assign out_bit     = r_shreg[0];
  assign out_last    = w_last;
  assign xz_count    = r_xz_count;
  assign xz_flag     = r_xz_flag;
  assign frames_done = r_frames;

endmodule

// File: tb/tb_xz_word_serializer.sv
// Directed bench for xz_word_serializer: table of frames plus
// reset-mid-frame, held-valid and frame-counter wrap sequences.
module tb_xz_word_serializer;

  logic        clk;
  logic        rst_n;
  logic [17:0] in_word;
  logic signed [31:0] in_len;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [4:0]  xz_count;
  logic        xz_flag;
  logic [7:0]  frames_done;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_frames;

  typedef struct {
    logic [17:0] word;
    int          len;
    int          exp_len;
    bit          bp;
    bit          keep;
  } vec_t;

  xz_word_serializer #(.WORD_W(18), .FCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_word(in_word), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .xz_count(xz_count), .xz_flag(xz_flag),
    .frames_done(frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic capture(input logic [17:0] w, input int l);
    int t;
    t = 0;
    in_word  = w;
    in_len   = l;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    check("cap_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called on the negedge after capture; stop>0 ends early.
  task automatic drain(input logic [17:0] w, input int n,
                       input bit bp, input int stop);
    logic [17:0] ew;
    int xc, acc, cyc, lim;
    xc = 0; acc = 0; cyc = 0;
    lim = (stop > 0) ? stop : n;
    for (int i = 0; i < 18; i++) begin
      ew[i] = (w[i] === 1'b1);
      if ($isunknown(w[i])) xc++;
    end
    check("xz_count", {27'd0, xz_count}, xc);
    check("xz_flag", {31'd0, xz_flag}, (xc != 0) ? 1 : 0);
    while (acc < lim && cyc < 200) begin
      out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      check("busy", {31'd0, in_ready}, 0);
      check("valid", {31'd0, out_valid}, 1);
      check("no_x", {31'd0, $isunknown({out_bit, out_last,
            out_valid, in_ready, xz_count, xz_flag,
            frames_done})}, 0);
      check("bit", {31'd0, out_bit}, {31'd0, ew[acc]});
      check("last", {31'd0, out_last}, (acc == n - 1) ? 1 : 0);
      if (out_ready) acc++;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    check("accepted", acc, lim);
    out_ready = 1'b1;
    if (stop == 0) begin
      exp_frames = exp_frames + 8'd1;
      if (!bp) check("frame_cycles", cyc, n);
      check("idle_ready", {31'd0, in_ready}, 1);
      check("idle_valid", {31'd0, out_valid}, 0);
      check("idle_last", {31'd0, out_last}, 0);
      check("frames", {24'd0, frames_done}, {24'd0, exp_frames});
    end
  endtask

  vec_t tv[9];

  initial begin
    logic [17:0] xw;
    n_cmp = 0;
    n_bad = 0;
    exp_frames = 8'd0;
    xw = 18'b00_0000_0000_0000_0zx1;
    tv[0] = '{18'h2A5A5, 13, 13, 1'b0, 1'b0};
    tv[1] = '{xw,         4,  4, 1'b0, 1'b0};
    tv[2] = '{18'h3C5A3, 18, 18, 1'b1, 1'b0};
    tv[3] = '{18'h12345,  0, 18, 1'b0, 1'b1};
    tv[4] = '{18'h2F0F1, -5, 18, 1'b0, 1'b1};
    tv[5] = '{18'h0AAAA, 40, 18, 1'b0, 1'b0};
    tv[6] = '{18'h155AB,  1,  1, 1'b0, 1'b0};
    tv[7] = '{18'h3FFFF, 19, 18, 1'b0, 1'b0};
    tv[8] = '{18'h20001, 18, 18, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_word   = '0;
    in_len    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_bit", {31'd0, out_bit}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_xz", {26'd0, xz_flag, xz_count}, 0);
    check("rst_frames", {24'd0, frames_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 1);

    // Reset mid-frame after 6 of 13 bits.
    capture(18'h2A5A5, 13);
    in_valid = 1'b0;
    drain(18'h2A5A5, 13, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_ready", {31'd0, in_ready}, 0);
    check("mid_rst_frames", {24'd0, frames_done}, 0);
    check("mid_rst_bit", {31'd0, out_bit}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, in_ready}, 1);

    for (int i = 0; i < 9; i++) begin
      capture(tv[i].word, tv[i].len);
      if (tv[i].keep) begin
        in_word = tv[i + 1].word;
        in_len  = tv[i + 1].len;
      end else begin
        in_valid = 1'b0;
      end
      drain(tv[i].word, tv[i].exp_len, tv[i].bp, 0);
    end

    while (exp_frames != 8'd255) begin
      capture(18'(exp_frames) ^ 18'h15555, 1);
      in_valid = 1'b0;
      drain(18'(exp_frames) ^ 18'h15555, 1, 1'b0, 0);
    end
    check("at_255", {24'd0, frames_done}, 32'd255);
    capture(18'h00001, 1);
    in_valid = 1'b0;
    drain(18'h00001, 1, 1'b0, 0);
    check("wrap_0", {24'd0, frames_done}, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
